instr_fetch: RTL and testbench

- Program-counter and fetch stage that sits directly upstream of the control decoder.
- Sequences the PC, presents the 9-bit instruction word to the decoder, and consumes the decoder's 2-bit branch code and 4-bit LUT index to redirect the PC.
- Owns the 16-entry branch-target LUT, which is loaded before a run.
- Owns the run/done handshake with the testbench/top level.

---
 rtl/fetch_pkg.sv | 32 +++
 rtl/branch_lut.sv | 39 +++
 rtl/instr_fetch.sv | 121 ++++++++++++
 tb/tb_instr_fetch.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
//------------------------------------------------------------------------------
// Module : fetch_pkg
// Shared fetch/decoder constants, state encoding and branch-condition helper.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package fetch_pkg;

    localparam int LUT_IDX_W = 4;

    localparam logic [1:0] BR_NONE   = 2'b00;
    localparam logic [1:0] BR_SC     = 2'b01;
    localparam logic [1:0] BR_NSC    = 2'b10;
    localparam logic [1:0] BR_ALWAYS = 2'b11;

    localparam logic [8:0] NOP_INSTR  = 9'b001101111;
    localparam logic [8:0] HALT_INSTR = 9'b001101110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic branch_taken(input logic [1:0] code, input logic flag);
        return (code == BR_ALWAYS) | ((code == BR_SC) & flag) | ((code == BR_NSC) & ~flag);
    endfunction

endpackage

`default_nettype wire

// File: rtl/branch_lut.sv
//------------------------------------------------------------------------------
// Module : branch_lut
// Branch-target register file: one write port, one combinational read port.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module branch_lut #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int DW    = 10
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // A write lands at the clock edge, so a same-cycle read sees the old entry.
    assign rdata_o = mem_q[raddr_i];

endmodule

`default_nettype wire

// File: rtl/instr_fetch.sv
//------------------------------------------------------------------------------
// Module : instr_fetch
// PC sequencer / fetch stage with branch-target LUT and run/done handshake.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module instr_fetch
    import fetch_pkg::*;
#(
    parameter int PC_W      = 10,
    parameter int INSTR_W   = 9,
    parameter int LUT_DEPTH = 16,
    parameter int CNT_W     = 16
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 start,
    input  logic                 stall,
    input  logic [1:0]           branch,
    input  logic [LUT_IDX_W-1:0] target_lut,
    input  logic                 sc_flag,
    input  logic                 lut_wr_en,
    input  logic [LUT_IDX_W-1:0] lut_wr_addr,
    input  logic [PC_W-1:0]      lut_wr_data,
    output logic [PC_W-1:0]      imem_addr,
    input  logic [INSTR_W-1:0]   imem_data,
    output logic [INSTR_W-1:0]   instr,
    output logic                 instr_valid,
    output logic                 done,
    output logic [CNT_W-1:0]     cycle_count
);

    localparam logic [INSTR_W-1:0] C_NOP  = INSTR_W'(NOP_INSTR);
    localparam logic [INSTR_W-1:0] C_HALT = INSTR_W'(HALT_INSTR);

    state_t           state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PC_W-1:0]  lut_rdata;
    logic             lut_we;
    logic             is_halt;
    logic             taken;

    branch_lut #(
        .DEPTH (LUT_DEPTH),
        .AW    (LUT_IDX_W),
        .DW    (PC_W)
    ) u_lut (
        .clk_i   (Clk),
        .rst_i   (Reset),
        .we_i    (lut_we),
        .waddr_i (lut_wr_addr),
        .wdata_i (lut_wr_data),
        .raddr_i (target_lut),
        .rdata_o (lut_rdata)
    );

    assign is_halt = (imem_data == C_HALT);
    assign taken   = branch_taken(branch, sc_flag);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_RUN;
                    pc_d    = '0;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                if (!stall) begin
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    // HALT outranks any branch; PC stays on the HALT address.
                    if (is_halt) begin
                        state_d = ST_DONE;
                    end else if (taken) begin
                        pc_d = lut_rdata;
                    end else if (pc_q == '1) begin
                        state_d = ST_DONE;
                    end else begin
                        pc_d = pc_q + PC_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        instr_valid = (state_q == ST_RUN);
        done        = (state_q == ST_DONE);
        instr       = (state_q == ST_RUN) ? imem_data : C_NOP;
        lut_we      = lut_wr_en & (state_q != ST_RUN);
    end

    assign imem_addr   = pc_q;
    assign cycle_count = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch.sv
//------------------------------------------------------------------------------
// Module : tb_instr_fetch
// Directed stimulus with an expected-fetch queue checked by a separate monitor.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_instr_fetch;
    import fetch_pkg::*;

    localparam int PC_W    = 10;
    localparam int INSTR_W = 9;
    localparam int CNT_W   = 16;

    logic               Clk = 1'b0;
    logic               Reset, start, stall, sc_flag, lut_wr_en;
    logic [1:0]         branch;
    logic [3:0]         target_lut, lut_wr_addr;
    logic [PC_W-1:0]    lut_wr_data, imem_addr;
    logic [INSTR_W-1:0] imem_data, instr;
    logic               instr_valid, done;
    logic [CNT_W-1:0]   cycle_count;

    logic [INSTR_W-1:0] mem  [1024];
    logic [1:0]         br_a [1024];
    logic [3:0]         tg_a [1024];

    typedef struct {
        int pc;
        int cnt;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    int n_pass  = 0;
    int n_total = 0;

    int t3_code[4] = '{1, 1, 2, 2};
    int t3_sc[4]   = '{0, 1, 0, 1};
    int t3_dst[4]  = '{8, 40, 40, 8};

    always #5 Clk = ~Clk;

    // Memory and a stand-in decoder, both combinational on the fetch address.
    assign imem_data  = mem[imem_addr];
    assign branch     = br_a[imem_addr];
    assign target_lut = tg_a[imem_addr];

    instr_fetch #(
        .PC_W      (PC_W),
        .INSTR_W   (INSTR_W),
        .LUT_DEPTH (16),
        .CNT_W     (CNT_W)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .start       (start),
        .stall       (stall),
        .branch      (branch),
        .target_lut  (target_lut),
        .sc_flag     (sc_flag),
        .lut_wr_en   (lut_wr_en),
        .lut_wr_addr (lut_wr_addr),
        .lut_wr_data (lut_wr_data),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .instr       (instr),
        .instr_valid (instr_valid),
        .done        (done),
        .cycle_count (cycle_count)
    );

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    always @(negedge Clk) begin
        if (instr_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_fetch_pc", int'(imem_addr), -1);
            end else begin
                mon_e = exp_q.pop_front();
                check("fetch_pc", int'(imem_addr), mon_e.pc);
                check("fetch_cnt", int'(cycle_count), mon_e.cnt);
                check("fetch_instr", int'(instr), int'(mem[mon_e.pc]));
            end
        end
    end

    task automatic push(input int pc, input int cnt);
        exp_t e;
        e.pc  = pc;
        e.cnt = cnt;
        exp_q.push_back(e);
    endtask

    task automatic push_seq(input int lo, input int hi);
        for (int p = lo; p <= hi; p++) push(p, p);
    endtask

    task automatic init_prog();
        for (int i = 0; i < 1024; i++) begin
            mem[i]  = '0;
            br_a[i] = BR_NONE;
            tg_a[i] = '0;
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic lut_write(input int a, input int d);
        lut_wr_en   = 1'b1;
        lut_wr_addr = 4'(a);
        lut_wr_data = PC_W'(d);
        tick();
        lut_wr_en   = 1'b0;
    endtask

    task automatic wait_pc(input int p, input int budget);
        for (int k = 0; k < budget && int'(imem_addr) != p; k++) tick();
        if (int'(imem_addr) != p) check("wait_pc_timeout", int'(imem_addr), p);
    endtask

    task automatic finish_run(input int fcnt, input int fpc, input int budget);
        for (int k = 0; k < budget && !done; k++) tick();
        check("done", int'(done), 1);
        check("final_count", int'(cycle_count), fcnt);
        check("final_pc", int'(imem_addr), fpc);
        check("idle_instr_nop", int'(instr), int'(NOP_INSTR));
        check("done_valid_low", int'(instr_valid), 0);
        check("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "timeout");
    end

    initial begin
        Reset = 1'b1; start = 1'b0; stall = 1'b0; sc_flag = 1'b0;
        lut_wr_en = 1'b0; lut_wr_addr = '0; lut_wr_data = '0;
        init_prog();
        repeat (2) @(posedge Clk);
        #1 Reset = 1'b0;

        check("rst_valid", int'(instr_valid), 0);
        check("rst_done", int'(done), 0);
        check("rst_pc", int'(imem_addr), 0);
        check("rst_count", int'(cycle_count), 0);
        check("rst_instr_nop", int'(instr), int'(NOP_INSTR));

        // Straight-line run ending in HALT at 4
        mem[4] = HALT_INSTR;
        push_seq(0, 4);
        pulse_start();
        finish_run(5, 4, 30);

        // Unconditional branch through lut[3]=20
        init_prog();
        lut_write(3, 20);
        br_a[2] = BR_ALWAYS; tg_a[2] = 4'd3;
        mem[22] = HALT_INSTR;
        push_seq(0, 2); push(20, 3); push(21, 4); push(22, 5);
        pulse_start();
        finish_run(6, 22, 30);

        // Conditional branches at PC 7 through lut[5]=40
        lut_write(5, 40);
        for (int t = 0; t < 4; t++) begin
            init_prog();
            br_a[7] = 2'(t3_code[t]); tg_a[7] = 4'd5;
            mem[8] = HALT_INSTR; mem[40] = HALT_INSTR;
            sc_flag = t3_sc[t][0];
            push_seq(0, 7); push(t3_dst[t], 8);
            pulse_start();
            finish_run(9, t3_dst[t], 30);
        end
        sc_flag = 1'b0;

        // Stall three cycles at PC 6 with an always-branch pending
        init_prog();
        br_a[6] = BR_ALWAYS; tg_a[6] = 4'd3;
        mem[20] = HALT_INSTR;
        push_seq(0, 5);
        for (int k = 0; k < 4; k++) push(6, 6);
        push(20, 7);
        pulse_start();
        wait_pc(6, 20);
        stall = 1'b1;
        repeat (3) tick();
        stall = 1'b0;
        finish_run(8, 20, 30);

        // LUT write and start pulse during RUN are both ignored
        init_prog();
        br_a[8] = BR_ALWAYS; tg_a[8] = 4'd3;
        mem[20] = HALT_INSTR; mem[99] = HALT_INSTR;
        push_seq(0, 8); push(20, 9);
        pulse_start();
        wait_pc(2, 20);
        lut_wr_en = 1'b1; lut_wr_addr = 4'd3; lut_wr_data = 10'd99; start = 1'b1;
        tick();
        lut_wr_en = 1'b0; start = 1'b0;
        finish_run(10, 20, 40);

        // LUT write together with start, then PC overflow at all-ones
        init_prog();
        br_a[1] = BR_ALWAYS; tg_a[1] = 4'd7;
        push(0, 0); push(1, 1); push(1023, 2);
        lut_wr_en = 1'b1; lut_wr_addr = 4'd7; lut_wr_data = 10'd1023; start = 1'b1;
        tick();
        lut_wr_en = 1'b0; start = 1'b0;
        finish_run(3, 1023, 20);

        // Asynchronous reset mid-run at PC 12
        init_prog();
        push_seq(0, 11);
        pulse_start();
        wait_pc(12, 30);
        #2 Reset = 1'b1;
        #1;
        check("async_rst_valid", int'(instr_valid), 0);
        check("async_rst_pc", int'(imem_addr), 0);
        check("async_rst_done", int'(done), 0);
        check("async_rst_count", int'(cycle_count), 0);
        check("async_rst_instr", int'(instr), int'(NOP_INSTR));
        check("async_rst_queue", exp_q.size(), 0);
        @(posedge Clk);
        #1 Reset = 1'b0;

        // Restart: lut[3] was cleared, so the branch at 5 lands on 0
        init_prog();
        br_a[5] = BR_ALWAYS; tg_a[5] = 4'd3;
        push_seq(0, 5); push(0, 6);
        pulse_start();
        wait_pc(5, 20);
        mem[0] = HALT_INSTR;
        finish_run(7, 0, 20);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
